// File: rtl/t_inst_pipe.sv
// Elastic inversion pipeline with a stall-on-backpressure shift chain, a
// zero-latency combinational twin path, a rotating XOR trace signature and an output transfer counter.
module t_inst_pipe #(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 2,
   parameter int INVERT  = 1,
   parameter int TRACE_W = 128
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_valid,
   output logic               i_ready,
   input  logic [WIDTH-1:0]   i_seq,
   output logic               o_valid,
   input  logic               o_ready,
   output logic [WIDTH-1:0]   o_seq_dNr,
   input  logic [WIDTH-1:0]   i_com,
   output logic [WIDTH-1:0]   o_com,
   input  logic               trace_en,
   input  logic [TRACE_W-1:0] wide_for_trace,
   input  logic [TRACE_W-1:0] wide_for_trace_2,
   output logic [TRACE_W-1:0] trace_sig,
   output logic [15:0]        xfer_cnt
);

   logic [WIDTH-1:0] stage_data [DEPTH];
   logic             stage_vld  [DEPTH];
   logic             stall;
   logic [WIDTH-1:0] seq_xform;

   assign o_com     = (INVERT != 0) ? ~i_com : i_com;
   assign seq_xform = (INVERT != 0) ? ~i_seq : i_seq;

   assign o_valid   = stage_vld[DEPTH-1];
   assign o_seq_dNr = stage_data[DEPTH-1];
   assign stall     = o_valid & ~o_ready;
   assign i_ready   = ~stall;

   // Stage-0 data only loads on a real transfer so the output word stays at
   // the last accepted value instead of tracking idle input noise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_data[i] <= '0;
            stage_vld[i]  <= 1'b0;
         end
      end else if (!stall) begin
         stage_vld[0] <= i_valid;
         if (i_valid)
            stage_data[0] <= seq_xform;
         for (int i = 1; i < DEPTH; i++) begin
            stage_data[i] <= stage_data[i-1];
            stage_vld[i]  <= stage_vld[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         trace_sig <= '0;
      else if (trace_en)
         trace_sig <= {trace_sig[TRACE_W-2:0], trace_sig[TRACE_W-1]}
                      ^ wide_for_trace ^ wide_for_trace_2;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         xfer_cnt <= '0;
      else if (o_valid && o_ready)
         xfer_cnt <= xfer_cnt + 16'd1;
   end

endmodule

// File: tb/tb_t_inst_pipe.sv
// Directed bench for t_inst_pipe: default build (DEPTH=2, INVERT=1) plus a
// DEPTH=4, INVERT=0 build used for the pass-through and full-pipe reset cases.
module tb_t_inst_pipe;

   logic         clk = 1'b0;
   logic         rst_n;

   logic         i_valid, o_ready, trace_en;
   logic [7:0]   i_seq, i_com;
   logic [127:0] wt1, wt2;
   logic         i_ready, o_valid;
   logic [7:0]   o_seq, o_com;
   logic [127:0] trace_sig;
   logic [15:0]  xfer_cnt;

   logic         d_ivalid, d_oready, d_trace_en;
   logic [7:0]   d_iseq, d_icom;
   logic [127:0] d_wt1, d_wt2;
   logic         d_iready, d_ovalid;
   logic [7:0]   d_oseq, d_ocom;
   logic [127:0] d_trace_sig;
   logic [15:0]  d_xfer_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   t_inst_pipe u_dut (
      .clk(clk), .rst_n(rst_n),
      .i_valid(i_valid), .i_ready(i_ready), .i_seq(i_seq),
      .o_valid(o_valid), .o_ready(o_ready), .o_seq_dNr(o_seq),
      .i_com(i_com), .o_com(o_com),
      .trace_en(trace_en), .wide_for_trace(wt1), .wide_for_trace_2(wt2),
      .trace_sig(trace_sig), .xfer_cnt(xfer_cnt)
   );

   t_inst_pipe #(.WIDTH(8), .DEPTH(4), .INVERT(0), .TRACE_W(128)) u_d4 (
      .clk(clk), .rst_n(rst_n),
      .i_valid(d_ivalid), .i_ready(d_iready), .i_seq(d_iseq),
      .o_valid(d_ovalid), .o_ready(d_oready), .o_seq_dNr(d_oseq),
      .i_com(d_icom), .o_com(d_ocom),
      .trace_en(d_trace_en), .wide_for_trace(d_wt1), .wide_for_trace_2(d_wt2),
      .trace_sig(d_trace_sig), .xfer_cnt(d_xfer_cnt)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int idx, nout, nx, sent;
      bit seen, chk_ffff;
      logic [7:0] exp_seq [16];

      rst_n = 1'b0; i_valid = 1'b1; o_ready = 1'b0; trace_en = 1'b1;
      i_seq = 8'h11; i_com = 8'h00; wt1 = '1; wt2 = '0;
      d_ivalid = 1'b0; d_oready = 1'b1; d_trace_en = 1'b0;
      d_iseq = 8'h00; d_icom = 8'h00; d_wt1 = '0; d_wt2 = '0;
      repeat (3) tick();

      // reset state; inputs are active but must be ignored
      chk("rst_o_valid",   o_valid,   0);
      chk("rst_o_seq",     o_seq,     0);
      chk("rst_i_ready",   i_ready,   1);
      chk("rst_trace_sig", trace_sig, 0);
      chk("rst_xfer_cnt",  xfer_cnt,  0);

      i_com = 8'h3C; d_icom = 8'h3C; #1;
      chk("o_com_inv1", o_com,  8'hC3);
      chk("o_com_inv0", d_ocom, 8'h3C);
      i_com = 8'hF0; d_icom = 8'h81; #1;
      chk("o_com_inv1_b", o_com,  8'h0F);
      chk("o_com_inv0_b", d_ocom, 8'h81);

      // single item latency
      trace_en = 1'b0; wt1 = '0;
      rst_n = 1'b1; o_ready = 1'b1; i_valid = 1'b1; i_seq = 8'h5A;
      tick();
      i_valid = 1'b0; i_seq = 8'h00;
      chk("lat_cycle1_valid", o_valid, 0);
      tick();
      chk("lat_cycle2_valid", o_valid, 1);
      chk("lat_cycle2_data",  o_seq,   8'hA5);
      chk("lat_cycle2_cnt",   xfer_cnt, 0);
      tick();
      chk("lat_xfer_cnt",     xfer_cnt, 1);
      chk("lat_bubble",       o_valid,  0);
      chk("lat_hold_data",    o_seq,    8'hA5);

      // trace signature
      chk("trace_idle", trace_sig, 0);
      trace_en = 1'b1; wt1 = 128'h1; wt2 = 128'h2;
      tick();
      chk("trace_step1", trace_sig, 128'h3);
      wt1 = '0; wt2 = '0;
      tick();
      chk("trace_step2", trace_sig, 128'h6);
      trace_en = 1'b0; wt1 = 128'hFF;
      tick();
      chk("trace_hold", trace_sig, 128'h6);
      trace_en = 1'b1; wt1 = {1'b1, 127'h0}; wt2 = '0;
      tick();
      chk("trace_msb", trace_sig, {1'b1, 127'hC});
      wt1 = '0;
      tick();
      chk("trace_wrap", trace_sig, 128'h19);
      trace_en = 1'b0;

      // streaming 0x00..0x0F with backpressure on cycles 4..7
      for (int k = 0; k < 16; k++) exp_seq[k] = ~(k[7:0]);
      idx = 0; nout = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         i_valid = (idx < 16);
         i_seq   = idx[7:0];
         o_ready = !(cyc >= 4 && cyc <= 7);
         #1;
         if (cyc < 18)
            chk($sformatf("stream_i_ready_c%0d", cyc), i_ready, !(cyc >= 4 && cyc <= 7));
         if (o_valid && o_ready) begin
            if (nout < 16) chk($sformatf("stream_out%0d", nout), o_seq, exp_seq[nout]);
            nout++;
         end
         if (i_valid && i_ready) idx++;
         tick();
      end
      i_valid = 1'b0; o_ready = 1'b1;
      chk("stream_out_count", nout, 16);
      chk("stream_in_count",  idx,  16);
      chk("stream_xfer_cnt",  xfer_cnt, 17);

      // DEPTH=4: one transfer, then fill the pipe under backpressure
      d_ivalid = 1'b1; d_iseq = 8'h77; d_oready = 1'b1;
      tick();
      d_ivalid = 1'b0;
      repeat (5) tick();
      chk("d4_xfer_cnt", d_xfer_cnt, 1);
      chk("d4_last_data", d_oseq, 8'h77);
      d_oready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         d_ivalid = 1'b1; d_iseq = 8'h10 + k[7:0];
         tick();
      end
      d_ivalid = 1'b0;
      chk("d4_full_valid",  d_ovalid, 1);
      chk("d4_full_data",   d_oseq,   8'h10);
      chk("d4_full_iready", d_iready, 0);

      rst_n = 1'b0; d_ivalid = 1'b1; d_iseq = 8'hEE; d_oready = 1'b1; d_trace_en = 1'b1; d_wt1 = '1;
      tick();
      chk("d4_rst_valid",  d_ovalid,    0);
      chk("d4_rst_cnt",    d_xfer_cnt,  0);
      chk("d4_rst_data",   d_oseq,      0);
      chk("d4_rst_iready", d_iready,    1);
      chk("d4_rst_trace",  d_trace_sig, 0);
      rst_n = 1'b1; d_ivalid = 1'b0; d_trace_en = 1'b0; d_wt1 = '0;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (d_ovalid) seen = 1'b1;
         tick();
      end
      chk("d4_no_stale", seen, 0);
      chk("d4_post_cnt", d_xfer_cnt, 0);

      // 65536 output transfers wrap the counter
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; o_ready = 1'b1;
      nx = 0; sent = 0; chk_ffff = 1'b0;
      for (int cyc = 0; cyc < 70000 && nx < 65536; cyc++) begin
         i_valid = (sent < 65536);
         i_seq   = sent[7:0];
         #1;
         if (o_valid && o_ready) nx++;
         if (i_valid && i_ready) sent++;
         tick();
         if (nx == 65535 && !chk_ffff) begin
            chk_ffff = 1'b1;
            chk("wrap_ffff", xfer_cnt, 16'hFFFF);
         end
      end
      i_valid = 1'b0;
      chk("wrap_count", nx, 65536);
      chk("wrap_zero",  xfer_cnt, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
